// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B4 word-addressed RAM slave with wait states, registered-feedback bursts and ERR on out-of-range.
module wb_ram_slave #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_DEPTH     = 1024,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     WB_CLK_I,
  input  logic                     WB_RST_I,
  input  logic [WB_ADDR_WIDTH-1:0] WB_ADR_I,
  input  logic [WB_DATA_WIDTH-1:0] WB_DAT_I,
  output logic [WB_DATA_WIDTH-1:0] WB_DAT_O,
  input  logic                     WB_WE_I,
  input  logic                     WB_STB_I,
  input  logic                     WB_CYC_I,
  input  logic [2:0]               WB_CTI_I,
  output logic                     WB_ACK_O,
  output logic                     WB_ERR_O,
  output logic                     WB_RTY_O,
  output logic                     WB_STALL_O
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [WB_ADDR_WIDTH:0] DEPTH = (WB_ADDR_WIDTH+1)'(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, BEAT, BURST} state_t;
  state_t                   r_state;
  logic [3:0]               r_cnt;
  logic [WB_ADDR_WIDTH-1:0] r_adr;
  logic                     r_ack, r_err;
  logic [WB_DATA_WIDTH-1:0] r_dat;
  logic [WB_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic                     w_req, w_in, w_go, w_cont, w_nxt_in;
  logic [WB_ADDR_WIDTH:0]   w_nxt;
  assign w_req    = WB_CYC_I & WB_STB_I;
  assign w_in     = {1'b0, WB_ADR_I} < DEPTH;
  assign w_go     = w_req && (r_state == IDLE ? (WAIT_STATES == 0 && !r_ack && !r_err)
                                              : (r_state == WAIT && r_cnt == 4'd1));
  assign w_cont   = w_req && !r_err && (WB_CTI_I == 3'b001 || WB_CTI_I == 3'b010);
  assign w_nxt    = {1'b0, r_adr} + (WB_ADDR_WIDTH+1)'(WB_CTI_I == 3'b010);
  assign w_nxt_in = w_nxt < DEPTH;
  assign WB_ACK_O   = r_ack & w_req;
  assign WB_ERR_O   = r_err & w_req;
  assign WB_DAT_O   = r_dat;
  assign WB_RTY_O   = 1'b0;
  assign WB_STALL_O = 1'b0;
  always_ff @(posedge WB_CLK_I)
    if (!WB_RST_I && r_ack && w_req && WB_WE_I) r_mem[WB_ADR_I[IW-1:0]] <= WB_DAT_I;
  always_ff @(posedge WB_CLK_I) begin
    r_ack <= 1'b0;
    r_err <= 1'b0;
    if (WB_RST_I || !WB_CYC_I) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      if (WB_RST_I) r_dat <= '0;
    end else if (w_go) begin
      r_state <= BEAT;
      r_cnt   <= '0;
      r_ack   <= w_in;
      r_err   <= !w_in;
      r_adr   <= WB_ADR_I;
      r_dat   <= w_in ? r_mem[WB_ADR_I[IW-1:0]] : '0;
    end else if (r_state == IDLE) begin
      if (w_req && !r_ack && !r_err) begin
        r_state <= WAIT;
        r_cnt   <= 4'(WAIT_STATES);
      end
    end else if (r_state == WAIT) begin
      r_state <= w_req ? WAIT : IDLE;
      r_cnt   <= r_cnt - 4'd1;
    end else begin
      // burst beats read the predicted address, not whatever the master drives
      r_state <= !w_cont ? IDLE : w_nxt_in ? BURST : BEAT;
      r_ack   <= w_cont && w_nxt_in;
      r_err   <= w_cont && !w_nxt_in;
      r_adr   <= w_nxt[WB_ADDR_WIDTH-1:0];
      if (w_cont) r_dat <= w_nxt_in ? r_mem[w_nxt[IW-1:0]] : '0;
    end
  end
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: table-driven classic accesses plus burst, boundary, wait-state and reset sequences with a response scoreboard.
module tb_wb_ram_slave;
  localparam int DEPTH = 1024;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] adr = '0, dat_i = '0, dat_o, dat_o2;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0, stb2 = 1'b0, cyc2 = 1'b0;
  logic [2:0]  cti = '0;
  logic        ack, err, rty, stall, ack2, err2, rty2, stall2;
  typedef struct {logic we; logic [31:0] adr; logic [31:0] dat; logic err; logic [31:0] exp;} vec_t;
  typedef struct {logic err; logic rd; logic [31:0] d;} exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  wb_ram_slave u_dut (
    .WB_CLK_I(clk), .WB_RST_I(rst), .WB_ADR_I(adr), .WB_DAT_I(dat_i), .WB_DAT_O(dat_o),
    .WB_WE_I(we), .WB_STB_I(stb), .WB_CYC_I(cyc), .WB_CTI_I(cti),
    .WB_ACK_O(ack), .WB_ERR_O(err), .WB_RTY_O(rty), .WB_STALL_O(stall)
  );
  wb_ram_slave #(.WAIT_STATES(2)) u_ws (
    .WB_CLK_I(clk), .WB_RST_I(rst), .WB_ADR_I(adr), .WB_DAT_I(dat_i), .WB_DAT_O(dat_o2),
    .WB_WE_I(we), .WB_STB_I(stb2), .WB_CYC_I(cyc2), .WB_CTI_I(cti),
    .WB_ACK_O(ack2), .WB_ERR_O(err2), .WB_RTY_O(rty2), .WB_STALL_O(stall2)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic respond(input string name, output int lat);
    exp_t e;
    lat = 0;
    @(negedge clk);
    while (!(ack || err) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check({name, "_ack"}, 32'(ack), 32'(!e.err));
    check({name, "_err"}, 32'(err), 32'(e.err));
    if (e.err || e.rd) check({name, "_dat"}, dat_o, e.err ? 32'h0 : e.d);
  endtask
  task automatic classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic e_err, input logic [31:0] e_d);
    int          lat;
    logic [31:0] held;
    sb.push_back('{e_err, !w, e_d});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; cti = 3'b000;
    respond("classic", lat);
    check("classic_lat", 32'(lat), 32'd1);
    held = dat_o;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("classic_hold", dat_o, held);
  endtask
  task automatic burst(input logic w, input logic [31:0] a0, input int n, input logic incr,
                       input logic [31:0] d0, input logic [31:0] step, input int ek);
    int lat;
    for (int k = 0; k < n; k++) begin
      sb.push_back('{k == ek, !w, d0 + 32'(k) * step});
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w;
      adr   = incr ? a0 + 32'(k) : a0;
      dat_i = d0 + 32'(k) * step;
      cti   = (k == n - 1) ? 3'b111 : incr ? 3'b010 : 3'b001;
      respond("burst", lat);
      check("burst_lat", 32'(lat), k == 0 ? 32'd1 : 32'd0);
      if (k == ek) break;
    end
  endtask
  initial begin
    int lat;
    for (int i = 0; i < 10; i++)
      tbl.push_back('{1'b1, 32'(i), i == 5 ? 32'h5 : 32'hC0DE_0000 + 32'(i), 1'b0, 32'h0});
    for (int i = 0; i < 10; i++)
      tbl.push_back('{1'b0, 32'(i), 32'h0, 1'b0, i == 5 ? 32'h5 : 32'hC0DE_0000 + 32'(i)});
    tbl.push_back('{1'b1, 32'(DEPTH),     32'hDEAD_BEEF, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 32'h0,          32'h0,         1'b0, 32'hC0DE_0000});
    tbl.push_back('{1'b0, 32'(DEPTH + 3), 32'h0,         1'b1, 32'h0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack | ack2), 32'h0);
    check("rst_err", 32'(err | err2), 32'h0);
    check("rst_rty", 32'(rty | rty2), 32'h0);
    check("rst_stall", 32'(stall | stall2), 32'h0);
    check("rst_dat", dat_o | dat_o2, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++)
      classic(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].err, tbl[i].exp);
    burst(1'b1, 32'd8, 4, 1'b1, 32'hA0, 32'h1, -1);
    burst(1'b0, 32'd8, 4, 1'b1, 32'hA0, 32'h1, -1);
    classic(1'b0, 32'd11, 32'h0, 1'b0, 32'hA3);
    burst(1'b1, 32'd3, 3, 1'b0, 32'h11, 32'h11, -1);
    classic(1'b0, 32'd3, 32'h0, 1'b0, 32'h33);
    burst(1'b1, 32'(DEPTH - 1), 2, 1'b1, 32'h77, 32'h1, 1);
    classic(1'b0, 32'(DEPTH - 1), 32'h0, 1'b0, 32'h77);
    classic(1'b0, 32'd0, 32'h0, 1'b0, 32'hC0DE_0000);
    @(posedge clk); #1;
    adr = '0; we = 1'b0; cti = 3'b000; cyc2 = 1'b1; stb2 = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!(ack2 || err2) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ws_lat", 32'(lat), 32'd3);
    check("ws_ack", 32'(ack2), 32'd1);
    check("ws_err", 32'(err2), 32'd0);
    @(negedge clk);
    check("ws_ack_once", 32'(ack2 | err2), 32'd0);
    @(posedge clk); #1;
    cyc2 = 1'b0; stb2 = 1'b0;
    sb.push_back('{1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'd0; dat_i = 32'hB0; cti = 3'b010;
    respond("rstb0", lat);
    check("rstb0_lat", 32'(lat), 32'd1);
    sb.push_back('{1'b0, 1'b0, 32'h0});
    @(posedge clk); #1;
    adr = 32'd1; dat_i = 32'hB1;
    respond("rstb1", lat);
    check("rstb1_lat", 32'(lat), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ack", 32'(ack | err), 32'h0);
    check("midrst_dat", dat_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    classic(1'b0, 32'd0, 32'h0, 1'b0, 32'hB0);
    classic(1'b0, 32'd1, 32'h0, 1'b0, 32'hC0DE_0001);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
